// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory access arbiter.
//   state_t         : arbiter FSM states
//   PORT0/PORT1     : requester ids (port 0 = CPU load/store, port 1 = debug/loader)
//   DEF_ADDR_W/DEF_DATA_W/DEF_DEPTH : default address width, data width, word count
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 64;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_DEPTH  = 1024;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_access_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   pN_req/we/addr/wdata : requester N command (held stable until pN_ack)
//   pN_ack/err/rdata     : requester N one-cycle completion response
//   mem_*                : single-port memory controls and read data
//   busy                 : arbiter not idle
// Modports: slave = arbiter side, master = requester/memory side.
import dmem_arb_pkg::*;

interface dmem_access_arbiter_if #(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic              p0_err;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic              p1_err;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_ack, p0_err, p0_rdata,
        output p1_ack, p1_err, p1_rdata,
        output mem_address, mem_write, mem_read, mem_wdata,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_ack, p0_err, p0_rdata,
        input  p1_ack, p1_err, p1_rdata,
        input  mem_address, mem_write, mem_read, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/dmem_access_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
//   i_req[1:0] : request per port
//   i_prio     : port id currently holding priority
//   o_gnt_c    : granted port id (meaningful only when any request is high)
import dmem_arb_pkg::*;

module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_prio,
    output logic       o_gnt_c
);

    // Priority only breaks ties; a lone requester always wins.
    always_comb begin
        o_gnt_c = PORT0;
        if (i_req == 2'b11) begin
            o_gnt_c = i_prio;
        end else if (i_req[1]) begin
            o_gnt_c = PORT1;
        end
    end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares one single-port data memory between two requesters, one access at a time.
// Each access takes IDLE -> ACCESS (memory enable high) -> DONE (ack pulse).
//   i_clk  : clock, all state on posedge
//   i_rst  : asynchronous active-high reset
//   io_bus : requester ports, memory controls and busy (slave modport)
import dmem_arb_pkg::*;

module dmem_access_arbiter #(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    dmem_access_arbiter_if.slave  io_bus
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_prio;
    logic              r_id;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_write;
    logic              r_mem_read;
    logic              r_p0_ack;
    logic              r_p0_err;
    logic [DATA_W-1:0] r_p0_rdata;
    logic              r_p1_ack;
    logic              r_p1_err;
    logic [DATA_W-1:0] r_p1_rdata;
    logic              r_busy;

    logic [1:0]        w_req;
    logic              w_gnt;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_oor;
    logic              w_load;
    logic              w_finish;

    assign w_req = {io_bus.p1_req, io_bus.p0_req};

    rr_pick2 u_pick (
        .i_req   (w_req),
        .i_prio  (r_prio),
        .o_gnt_c (w_gnt)
    );

    // Winner's command fields
    assign w_sel_we    = (w_gnt == PORT1) ? io_bus.p1_we    : io_bus.p0_we;
    assign w_sel_addr  = (w_gnt == PORT1) ? io_bus.p1_addr  : io_bus.p0_addr;
    assign w_sel_wdata = (w_gnt == PORT1) ? io_bus.p1_wdata : io_bus.p0_wdata;
    assign w_sel_oor   = (w_sel_addr >= ADDR_W'(DEPTH));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_next_state = ACCESS;
            ACCESS:  w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State decode driving the datapath registers
    always_comb begin
        w_load   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE:    w_load   = |w_req;
            ACCESS:  w_finish = 1'b1;
            default: ;
        endcase
    end

    // Latched transaction, memory controls and responses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prio        <= PORT0;
            r_id          <= PORT0;
            r_we          <= 1'b0;
            r_err         <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_p0_ack      <= 1'b0;
            r_p0_err      <= 1'b0;
            r_p0_rdata    <= '0;
            r_p1_ack      <= 1'b0;
            r_p1_err      <= 1'b0;
            r_p1_rdata    <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_busy      <= (w_next_state != IDLE);
            // Enables are single-cycle pulses covering only the ACCESS cycle
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            if (w_load) begin
                r_id          <= w_gnt;
                r_we          <= w_sel_we;
                r_err         <= w_sel_oor;
                r_mem_address <= w_sel_addr;
                r_mem_wdata   <= w_sel_wdata;
                r_mem_write   <= w_sel_we & ~w_sel_oor;
                r_mem_read    <= ~w_sel_we & ~w_sel_oor;
                // Both tie-break and single-grant cases hand priority to the other port
                r_prio        <= ~w_gnt;
            end
            // Responses are live only in DONE; zero otherwise
            r_p0_ack   <= w_finish && (r_id == PORT0);
            r_p1_ack   <= w_finish && (r_id == PORT1);
            r_p0_err   <= w_finish && (r_id == PORT0) && r_err;
            r_p1_err   <= w_finish && (r_id == PORT1) && r_err;
            r_p0_rdata <= (w_finish && (r_id == PORT0) && !r_we && !r_err) ? io_bus.mem_rdata : '0;
            r_p1_rdata <= (w_finish && (r_id == PORT1) && !r_we && !r_err) ? io_bus.mem_rdata : '0;
        end
    end

    assign io_bus.mem_address = r_mem_address;
    assign io_bus.mem_wdata   = r_mem_wdata;
    assign io_bus.mem_write   = r_mem_write;
    assign io_bus.mem_read    = r_mem_read;
    assign io_bus.p0_ack      = r_p0_ack;
    assign io_bus.p0_err      = r_p0_err;
    assign io_bus.p0_rdata    = r_p0_rdata;
    assign io_bus.p1_ack      = r_p1_ack;
    assign io_bus.p1_err      = r_p1_err;
    assign io_bus.p1_rdata    = r_p1_rdata;
    assign io_bus.busy        = r_busy;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed self-checking bench for dmem_access_arbiter with a behavioural data memory.
module tb_dmem_access_arbiter;

    logic clk;
    logic rst;

    int n_asserts = 0;
    int n_fail    = 0;

    dmem_access_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    dmem_access_arbiter #(.ADDR_W(64), .DATA_W(64), .DEPTH(1024)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: write at posedge, read data updated at negedge of the enable cycle
    bit [63:0] mem [1024];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_address[9:0]] <= bus.mem_wdata;
    end
    always @(negedge clk) begin
        if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_address[9:0]];
    end

    // Protocol monitor: ack counts, ack overlap/adjacency, any memory enable seen
    int   n_ack0 = 0;
    int   n_ack1 = 0;
    logic prev_ack = 1'b0;
    logic ack_viol = 1'b0;
    logic en_seen  = 1'b0;
    always @(negedge clk) begin
        if (bus.p0_ack) n_ack0++;
        if (bus.p1_ack) n_ack1++;
        if (bus.p0_ack && bus.p1_ack) ack_viol = 1'b1;
        if ((bus.p0_ack || bus.p1_ack) && prev_ack) ack_viol = 1'b1;
        prev_ack = bus.p0_ack | bus.p1_ack;
        if (bus.mem_read || bus.mem_write) en_seen = 1'b1;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, ":p0_ack"}, bus.p0_ack, 1'b0);
        check1({tag, ":p1_ack"}, bus.p1_ack, 1'b0);
        check1({tag, ":p0_err"}, bus.p0_err, 1'b0);
        check1({tag, ":p1_err"}, bus.p1_err, 1'b0);
        check64({tag, ":p0_rdata"}, bus.p0_rdata, 64'h0);
        check64({tag, ":p1_rdata"}, bus.p1_rdata, 64'h0);
        check64({tag, ":mem_address"}, bus.mem_address, 64'h0);
        check64({tag, ":mem_wdata"}, bus.mem_wdata, 64'h0);
        check1({tag, ":mem_write"}, bus.mem_write, 1'b0);
        check1({tag, ":mem_read"}, bus.mem_read, 1'b0);
        check1({tag, ":busy"}, bus.busy, 1'b0);
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [63:0] addr, input logic [63:0] wdata);
        if (port) begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end else begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end
    endtask

    // One isolated transaction from IDLE: ACCESS cycle, DONE cycle, back to IDLE
    task automatic txn(input string tag, input logic port, input logic we,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic exp_err, input logic [63:0] exp_rdata);
        drive(port, 1'b1, we, addr, wdata);
        cyc();
        check1({tag, ":acc_busy"}, bus.busy, 1'b1);
        check1({tag, ":acc_mem_write"}, bus.mem_write, we & ~exp_err);
        check1({tag, ":acc_mem_read"}, bus.mem_read, ~we & ~exp_err);
        check64({tag, ":acc_mem_address"}, bus.mem_address, addr);
        check1({tag, ":acc_ack"}, port ? bus.p1_ack : bus.p0_ack, 1'b0);
        cyc();
        check1({tag, ":ack"}, port ? bus.p1_ack : bus.p0_ack, 1'b1);
        check1({tag, ":other_ack"}, port ? bus.p0_ack : bus.p1_ack, 1'b0);
        check1({tag, ":err"}, port ? bus.p1_err : bus.p0_err, exp_err);
        check64({tag, ":rdata"}, port ? bus.p1_rdata : bus.p0_rdata, exp_rdata);
        check1({tag, ":done_mem_en"}, bus.mem_write | bus.mem_read, 1'b0);
        drive(port, 1'b0, 1'b0, 64'h0, 64'h0);
        cyc();
        check1({tag, ":idle_ack"}, bus.p0_ack | bus.p1_ack, 1'b0);
        check1({tag, ":idle_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        int ack_base;
        logic [63:0] exp_addr;
        logic [63:0] exp_data;
        logic        exp_port;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        cyc();
        cyc();
        check_all_zero("reset_init");
        rst = 1'b0;
        cyc();

        // Single write then read-back on port 0
        txn("p0_wr3", 1'b0, 1'b1, 64'd3, 64'hDEAD_BEEF, 1'b0, 64'h0);
        check64("mem3_after_wr", mem[3], 64'hDEAD_BEEF);
        txn("p0_rd3", 1'b0, 1'b0, 64'd3, 64'h0, 1'b0, 64'hDEAD_BEEF);

        // Reset while idle clears the held mem_address/mem_wdata
        rst = 1'b1;
        #1;
        check_all_zero("reset_idle");
        cyc();
        rst = 1'b0;
        cyc();

        // Reset during the ACCESS cycle of a write: aborted, no ack
        ack_base = n_ack0;
        drive(1'b0, 1'b1, 1'b1, 64'd5, 64'hAA);
        cyc();
        check1("rst_acc:mem_write", bus.mem_write, 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("reset_access");
        cyc();
        check64("rst_acc:mem5", mem[5], 64'h0);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        rst = 1'b0;
        cyc();
        cyc();
        cyc();
        check64("rst_acc:no_ack", 64'(n_ack0 - ack_base), 64'h0);
        check1("rst_acc:busy", bus.busy, 1'b0);

        // Out-of-range read on port 1: error ack, memory never enabled
        en_seen = 1'b0;
        txn("p1_oor", 1'b1, 1'b0, 64'd1024, 64'h0, 1'b1, 64'h0);
        check1("p1_oor:no_mem_en", en_seen, 1'b0);

        // Seed two words through port 1 writes
        txn("p1_wr1023", 1'b1, 1'b1, 64'd1023, 64'hCAFE_F00D_1234_5678, 1'b0, 64'h0);
        txn("p1_wr0", 1'b1, 1'b1, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0);

        // Back-to-back: p1 keeps req high across two reads
        drive(1'b1, 1'b1, 1'b0, 64'd0, 64'h0);
        cyc();
        check1("b2b:acc1_read", bus.mem_read, 1'b1);
        check64("b2b:acc1_addr", bus.mem_address, 64'd0);
        cyc();
        check1("b2b:ack1", bus.p1_ack, 1'b1);
        check64("b2b:rdata1", bus.p1_rdata, 64'h0123_4567_89AB_CDEF);
        drive(1'b1, 1'b1, 1'b0, 64'd1023, 64'h0);
        cyc();
        check1("b2b:idle_ack", bus.p1_ack, 1'b0);
        check1("b2b:idle_busy", bus.busy, 1'b0);
        cyc();
        check1("b2b:acc2_read", bus.mem_read, 1'b1);
        check64("b2b:acc2_addr", bus.mem_address, 64'd1023);
        cyc();
        check1("b2b:ack2", bus.p1_ack, 1'b1);
        check64("b2b:rdata2", bus.p1_rdata, 64'hCAFE_F00D_1234_5678);
        drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        cyc();
        check1("b2b:end_busy", bus.busy, 1'b0);

        // Request dropped during ACCESS: write still commits, exactly one ack
        ack_base = n_ack0;
        drive(1'b0, 1'b1, 1'b1, 64'd7, 64'h77);
        cyc();
        check1("drop:mem_write", bus.mem_write, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        cyc();
        check1("drop:ack", bus.p0_ack, 1'b1);
        cyc();
        check1("drop:ack_gone", bus.p0_ack, 1'b0);
        check64("drop:mem7", mem[7], 64'h77);
        cyc();
        check64("drop:ack_count", 64'(n_ack0 - ack_base), 64'd1);

        // Contention from reset: both read continuously, grants alternate 0,1,0,1
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 64'd3, 64'h0);
        drive(1'b1, 1'b1, 1'b0, 64'd7, 64'h0);
        for (int k = 0; k < 4; k++) begin
            exp_port = (k % 2 == 1);
            exp_addr = exp_port ? 64'd7 : 64'd3;
            exp_data = exp_port ? 64'h77 : 64'hDEAD_BEEF;
            cyc();
            check64($sformatf("cont%0d:addr", k), bus.mem_address, exp_addr);
            check1($sformatf("cont%0d:read", k), bus.mem_read, 1'b1);
            cyc();
            check1($sformatf("cont%0d:ack_win", k), exp_port ? bus.p1_ack : bus.p0_ack, 1'b1);
            check1($sformatf("cont%0d:ack_lose", k), exp_port ? bus.p0_ack : bus.p1_ack, 1'b0);
            check64($sformatf("cont%0d:rdata", k), exp_port ? bus.p1_rdata : bus.p0_rdata, exp_data);
            cyc();
            check1($sformatf("cont%0d:idle_ack", k), bus.p0_ack | bus.p1_ack, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        cyc();
        cyc();
        check1("ack_exclusive_nonadjacent", ack_viol, 1'b0);
        check1("final_busy", bus.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
